// File: rtl/icache_defs.sv
// ============================================================================
// Module   : icache_defs (package)
// Purpose  : Line geometry and refill FSM encodings shared by ICache and bridge.
// Revision : 1.0
// ============================================================================
`default_nettype none

package icache_defs;

  localparam int BLK_LEN  = 4;
  localparam int WORD_W   = 32;
  localparam int BLK_SIZE = BLK_LEN * WORD_W;
  localparam int ADDR_W   = 32;

  localparam int STATE_W = 2;
  localparam logic [STATE_W-1:0] ST_IDLE  = 2'd0;
  localparam logic [STATE_W-1:0] ST_ISSUE = 2'd1;
  localparam logic [STATE_W-1:0] ST_WAIT  = 2'd2;
  localparam logic [STATE_W-1:0] ST_DONE  = 2'd3;

endpackage

`default_nettype wire

// File: rtl/icache_refill_bridge.sv
// ============================================================================
// Module   : icache_refill_bridge
// Purpose  : Splits one ICache line refill into BLK_LEN word reads and returns the assembled line.
// Revision : 1.0
// ============================================================================
`default_nettype none

module icache_refill_bridge #(
  parameter int BLK_LEN  = 4,
  parameter int BLK_SIZE = 128,
  parameter int ADDR_W   = 32
) (
  input  logic                cpu_clk,
  input  logic                cpu_rst,
  input  logic [3:0]          mem_ren,
  input  logic [ADDR_W-1:0]   mem_raddr,
  output logic                mem_rrdy,
  output logic                mem_rvalid,
  output logic [BLK_SIZE-1:0] mem_rdata,
  output logic                bus_req,
  output logic [ADDR_W-1:0]   bus_addr,
  input  logic                bus_gnt,
  input  logic                bus_rvalid,
  input  logic [31:0]         bus_rdata
);

  import icache_defs::*;

  localparam int OFF_W  = $clog2(BLK_LEN * 4);
  localparam int BEAT_W = $clog2(BLK_LEN);

  logic [STATE_W-1:0]      state;
  logic [STATE_W-1:0]      state_nxt;
  logic [ADDR_W-OFF_W-1:0] r_base;
  logic [ADDR_W-OFF_W-1:0] w_base_nxt;
  logic [BEAT_W-1:0]       r_beat;
  logic [BEAT_W-1:0]       w_beat_nxt;
  logic                    w_ren;
  logic                    w_last;
  logic                    w_slot_we;
  logic                    w_rrdy_nxt;
  logic                    w_rvalid_nxt;
  logic                    w_req_nxt;
  logic [ADDR_W-1:0]       w_addr_nxt;

  assign w_ren  = |mem_ren;
  assign w_last = (r_beat == BEAT_W'(BLK_LEN - 1));

  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst) begin
      state      <= ST_IDLE;
      r_base     <= '0;
      r_beat     <= '0;
      mem_rrdy   <= 1'b1;
      mem_rvalid <= 1'b0;
      mem_rdata  <= '0;
      bus_req    <= 1'b0;
      bus_addr   <= '0;
    end else begin
      state      <= state_nxt;
      r_base     <= w_base_nxt;
      r_beat     <= w_beat_nxt;
      mem_rrdy   <= w_rrdy_nxt;
      mem_rvalid <= w_rvalid_nxt;
      bus_req    <= w_req_nxt;
      bus_addr   <= w_addr_nxt;
      if (w_slot_we) begin
        mem_rdata[r_beat * WORD_W +: WORD_W] <= bus_rdata;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (w_ren)      state_nxt = ST_ISSUE;
      ST_ISSUE: if (bus_gnt)    state_nxt = ST_WAIT;
      ST_WAIT:  if (bus_rvalid) state_nxt = w_last ? ST_DONE : ST_ISSUE;
      ST_DONE:                  state_nxt = ST_IDLE;
      default:                  state_nxt = ST_IDLE;
    endcase
  end

  // Outputs are registered, so they are derived from the state being entered.
  always_comb begin
    w_base_nxt = r_base;
    w_beat_nxt = r_beat;
    w_slot_we  = 1'b0;
    if (state == ST_IDLE && w_ren) begin
      w_base_nxt = mem_raddr[ADDR_W-1:OFF_W];
      w_beat_nxt = '0;
    end
    if (state == ST_WAIT && bus_rvalid) begin
      w_slot_we = 1'b1;
      if (!w_last) w_beat_nxt = r_beat + 1'b1;
    end
    w_rrdy_nxt   = (state_nxt == ST_IDLE);
    w_rvalid_nxt = (state_nxt == ST_DONE);
    w_req_nxt    = (state_nxt == ST_ISSUE);
    // Line-aligned base plus beat offset can never carry out of the line.
    w_addr_nxt   = w_req_nxt ? {w_base_nxt, w_beat_nxt, 2'b00} : bus_addr;
  end

endmodule

`default_nettype wire

// File: tb/tb_icache_refill_bridge.sv
// ============================================================================
// Module   : tb_icache_refill_bridge
// Purpose  : Randomized bench for icache_refill_bridge with a line-level reference model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_icache_refill_bridge;

  logic         cpu_clk = 1'b0;
  logic         cpu_rst = 1'b1;
  logic [3:0]   mem_ren = '0;
  logic [31:0]  mem_raddr = '0;
  logic         mem_rrdy;
  logic         mem_rvalid;
  logic [127:0] mem_rdata;
  logic         bus_req;
  logic [31:0]  bus_addr;
  logic         bus_gnt = 1'b0;
  logic         bus_rvalid = 1'b0;
  logic [31:0]  bus_rdata = '0;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int pulses_seen = 0;
  int pulses_exp = 0;

  icache_refill_bridge #(.BLK_LEN(4), .BLK_SIZE(128), .ADDR_W(32)) dut (
    .cpu_clk    (cpu_clk),
    .cpu_rst    (cpu_rst),
    .mem_ren    (mem_ren),
    .mem_raddr  (mem_raddr),
    .mem_rrdy   (mem_rrdy),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .bus_req    (bus_req),
    .bus_addr   (bus_addr),
    .bus_gnt    (bus_gnt),
    .bus_rvalid (bus_rvalid),
    .bus_rdata  (bus_rdata)
  );

  always #5 cpu_clk = ~cpu_clk;

  always @(posedge cpu_clk) cyc <= cyc + 1;
  always @(negedge cpu_clk) if (mem_rvalid) pulses_seen <= pulses_seen + 1;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge cpu_clk);
    #1;
  endtask

  // One full refill: line model is word k = (base + 4k) ^ key.
  task automatic refill(input logic [31:0] addr, input int maxd, input bit noise,
                        input int abort_beat, input bit chk_lat);
    logic [31:0]  key;
    logic [31:0]  base;
    logic [127:0] line;
    int t0;
    int d;
    key  = chk_lat ? 32'h0 : $urandom;
    base = {addr[31:4], 4'h0};
    for (int k = 0; k < 4; k++) line[32*k +: 32] = (base + 32'(4 * k)) ^ key;

    for (int i = 0; i < 20 && !mem_rrdy; i++) tick();
    chk("rrdy_before_req", mem_rrdy, 1);
    mem_ren   = noise ? 4'($urandom_range(1, 15)) : 4'hF;
    mem_raddr = addr;
    t0 = cyc;
    tick();
    mem_ren   = '0;
    mem_raddr = $urandom;
    chk("first_req_next_cycle", bus_req, 1);
    chk("rrdy_busy", mem_rrdy, 0);

    for (int beat = 0; beat < 4; beat++) begin
      for (int i = 0; i < 50 && !bus_req; i++) tick();
      chk("req_seen", bus_req, 1);
      chk("bus_addr", bus_addr, base + 32'(4 * beat));
      d = $urandom_range(0, maxd);
      repeat (d) begin
        if (noise) begin
          mem_ren    = 4'($urandom_range(1, 15));
          mem_raddr  = $urandom;
          bus_rvalid = 1'($urandom);
          bus_rdata  = $urandom;
        end
        tick();
        chk("req_hold", bus_req, 1);
        chk("rrdy_stays_low", mem_rrdy, 0);
      end
      mem_ren    = '0;
      bus_rvalid = 1'b0;
      bus_gnt    = 1'b1;
      tick();
      bus_gnt = 1'b0;
      chk("req_drop_after_gnt", bus_req, 0);

      if (beat == abort_beat) begin
        #2 cpu_rst = 1'b1;
        #1;
        chk("abort_req", bus_req, 0);
        chk("abort_rrdy", mem_rrdy, 1);
        chk("abort_rvalid", mem_rvalid, 0);
        chk("abort_rdata", mem_rdata, 0);
        chk("abort_addr", bus_addr, 0);
        tick();
        cpu_rst    = 1'b0;
        bus_rvalid = 1'b1;
        bus_rdata  = $urandom;
        tick();
        bus_rvalid = 1'b0;
        tick();
        chk("stray_no_rvalid", mem_rvalid, 0);
        chk("stray_no_req", bus_req, 0);
        chk("stray_rdata", mem_rdata, 0);
        return;
      end

      d = $urandom_range(0, maxd);
      repeat (d) begin
        if (noise) begin
          mem_ren   = 4'($urandom_range(1, 15));
          mem_raddr = $urandom;
        end
        tick();
        chk("one_outstanding", bus_req, 0);
        chk("no_early_rvalid", mem_rvalid, 0);
      end
      mem_ren    = '0;
      bus_rvalid = 1'b1;
      bus_rdata  = line[32*beat +: 32];
      tick();
      bus_rvalid = 1'b0;
      bus_rdata  = $urandom;
    end

    chk("rvalid_pulse", mem_rvalid, 1);
    chk("line", mem_rdata, line);
    chk("rrdy_in_done", mem_rrdy, 0);
    if (chk_lat) chk("latency", 128'(cyc - t0), 128'd9);
    pulses_exp++;
    tick();
    chk("rvalid_one_cycle", mem_rvalid, 0);
    chk("rdata_hold", mem_rdata, line);
    chk("rrdy_back", mem_rrdy, 1);
  endtask

  initial begin
    repeat (3) @(posedge cpu_clk);
    #1;
    chk("rst_rrdy", mem_rrdy, 1);
    chk("rst_rvalid", mem_rvalid, 0);
    chk("rst_rdata", mem_rdata, 0);
    chk("rst_req", bus_req, 0);
    chk("rst_addr", bus_addr, 0);
    cpu_rst = 1'b0;
    tick();

    refill(32'h0000_1234, 0, 1'b0, -1, 1'b1);
    chk("directed_line", mem_rdata, 128'h0000123C_00001238_00001234_00001230);

    for (int n = 0; n < 8; n++) refill($urandom, 5, 1'b0, -1, 1'b0);
    for (int n = 0; n < 4; n++) refill($urandom, 5, 1'b1, -1, 1'b0);
    refill(32'hFFFF_FFF8, 3, 1'b0, -1, 1'b0);
    refill(32'hFFFF_FFF8, 0, 1'b0, -1, 1'b1);
    refill($urandom, 2, 1'b0, 2, 1'b0);
    refill($urandom, 0, 1'b0, -1, 1'b1);
    refill($urandom, 0, 1'b0, -1, 1'b1);
    refill($urandom, 4, 1'b1, -1, 1'b0);

    tick();
    chk("rvalid_pulse_count", 128'(pulses_seen), 128'(pulses_exp));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
